fifo_rd_streamer: RTL

Read-side drain engine for the synchronous FIFO. It issues read requests to the FIFO, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents the words in order on a valid/ready stream to downstream logic. It also counts delivered words and flags any FIFO underflow. It is the consumer-side counterpart to the write-side traffic the FIFO bench already drives.

---
 rtl/fifo_rd_streamer.sv | 88 ++++++++
 1 files changed

// File: rtl/fifo_rd_streamer.sv
// Read-side drain engine: issues FIFO reads, absorbs the one-cycle read latency in a
// 2-entry in-order buffer and presents words on a valid/ready stream.
module fifo_rd_streamer #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_W-1:0]      words_out,
    output logic                  underflow_err,
    input  logic                  clr_err
);

    logic [FIFO_WIDTH-1:0] mem_q [2];
    logic                  head_q, head_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [CNT_W-1:0]      words_q, words_d;
    logic                  err_q, err_d;

    logic pop;
    logic capture;
    logic room;
    logic tail;

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = mem_q[head_q];
    assign pop       = m_valid && m_ready;
    assign capture   = inflight_q && !fifo_underflow;
    // occ + inflight never exceeds 2, so the tail is head offset by occ[0] whenever capturing.
    assign tail      = head_q ^ occ_q[0];

    // Slot is free once the buffered words plus the in-flight return leave room,
    // counting a same-cycle pop as credit.
    assign room = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    assign fifo_rd_en    = rst_n && enable && !fifo_empty && room;
    assign words_out     = words_q;
    assign underflow_err = err_q;

    always_comb begin
        occ_d   = occ_q;
        head_d  = head_q ^ pop;
        words_d = words_q + CNT_W'(pop);
        err_d   = err_q;
        case ({capture, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        // A new underflow takes priority over a clear in the same cycle.
        if (inflight_q && fifo_underflow) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            head_q     <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            words_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (capture) begin
                mem_q[tail] <= fifo_dout;
            end
            head_q     <= head_d;
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            words_q    <= words_d;
            err_q      <= err_d;
        end
    end

endmodule
